// File: rtl/exc_pkg.sv
// Shared exception-interface types and constants.
// Used by the external interrupt controller and its helpers.
package exc_pkg;

  localparam int N_SRC_DEF = 8;

  // EStatus code for external IRQs; must match the core's value.
  localparam logic [3:0] ESTATUS_EXT_IRQ = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, lowest set index wins. Combinational.
// Ports: req (N_SRC) in; valid, id (ID_W) out.
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt requester for the ExtIRQ/ExtIAck/ERet interface.
// Ports: clk, reset, irq_in, mask_we, mask_wdata, ExtIAck, ERet in;
//        ExtIRQ, irq_id, irq_pending, irq_mask, in_service,
//        serviced_count out.
module ext_irq_ctrl
  import exc_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = $clog2(N_SRC),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ExtIAck,
  input  logic             ERet,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] irq_pending,
  output logic [N_SRC-1:0] irq_mask,
  output logic             in_service,
  output logic [CNT_W-1:0] serviced_count
);

  irq_state_e state, state_n;

  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] sel;
  logic             sel_v;
  logic [ID_W-1:0]  win_id;
  logic             ack;

  assign rise = irq_in & ~irq_prev;
  assign sel  = irq_pending & ~irq_mask;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .req   (sel),
    .valid (sel_v),
    .id    (win_id)
  );

  always_comb begin
    state_n = state;
    ack     = 1'b0;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (sel_v) state_n = REQ;
      end
      REQ: begin
        if (ExtIAck) begin
          state_n = SERVICE;
          ack     = 1'b1;
        end
      end
      SERVICE: begin
        if (ERet) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (ack) clr[irq_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      irq_prev       <= '0;
      irq_pending    <= '0;
      irq_mask       <= '0;
      ExtIRQ         <= 1'b0;
      irq_id         <= '0;
      in_service     <= 1'b0;
      serviced_count <= '0;
    end else begin
      state    <= state_n;
      irq_prev <= irq_in;
      // A new edge beats the ack clear on the same bit.
      irq_pending <= (irq_pending & ~clr) | rise;
      if (mask_we) irq_mask <= mask_wdata;
      ExtIRQ     <= (state_n == REQ);
      in_service <= (state_n == SERVICE);
      // ID is captured once on entry to REQ, then frozen.
      if (state == IDLE && sel_v) irq_id <= win_id;
      if (ack) serviced_count <= serviced_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_ext_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        ExtIAck;
  logic        ERet;
  logic        ExtIRQ;
  logic [2:0]  irq_id;
  logic [7:0]  irq_pending;
  logic [7:0]  irq_mask;
  logic        in_service;
  logic [15:0] serviced_count;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ext_irq_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .irq_in         (irq_in),
    .mask_we        (mask_we),
    .mask_wdata     (mask_wdata),
    .ExtIAck        (ExtIAck),
    .ERet           (ERet),
    .ExtIRQ         (ExtIRQ),
    .irq_id         (irq_id),
    .irq_pending    (irq_pending),
    .irq_mask       (irq_mask),
    .in_service     (in_service),
    .serviced_count (serviced_count)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; irq_in = '0; mask_we = 1'b0;
    mask_wdata = '0; ExtIAck = 1'b0; ERet = 1'b0;
    tick(2);
    reset = 1'b0;
    n_run++;
    if ({ExtIRQ, irq_id, irq_pending, irq_mask,
         in_service, serviced_count} !== '0) begin
      n_fail++;
      $display("FAIL reset: irq=%b id=%0d pend=%h mask=%h svc=%b cnt=%0d want all 0",
               ExtIRQ, irq_id, irq_pending, irq_mask,
               in_service, serviced_count);
    end
    tick(1);
  endtask

  task automatic test_single;
    irq_in = 8'h08;
    tick(1);
    irq_in = 8'h00;
    n_run++;
    if (irq_pending !== 8'h08 || ExtIRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pend: pend=%h irq=%b want 08/0",
               irq_pending, ExtIRQ);
    end
    tick(1);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd3) begin
      n_fail++;
      $display("FAIL single_req: irq=%b id=%0d want 1/3", ExtIRQ, irq_id);
    end
    tick(2);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd3) begin
      n_fail++;
      $display("FAIL single_hold: irq=%b id=%0d want 1/3", ExtIRQ, irq_id);
    end
    ExtIAck = 1'b1;
    tick(1);
    ExtIAck = 1'b0;
    n_run++;
    if (ExtIRQ !== 1'b0 || in_service !== 1'b1 ||
        irq_pending !== 8'h00 || serviced_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_ack: irq=%b svc=%b pend=%h cnt=%0d want 0/1/00/1",
               ExtIRQ, in_service, irq_pending, serviced_count);
    end
    tick(3);
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    n_run++;
    if (in_service !== 1'b0 || ExtIRQ !== 1'b0 || irq_id !== 3'd3) begin
      n_fail++;
      $display("FAIL single_eret: svc=%b irq=%b id=%0d want 0/0/3",
               in_service, ExtIRQ, irq_id);
    end
  endtask

  task automatic test_priority;
    irq_in = 8'h24;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd2) begin
      n_fail++;
      $display("FAIL prio_sel: irq=%b id=%0d want 1/2", ExtIRQ, irq_id);
    end
    irq_in = 8'h01;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    n_run++;
    if (irq_id !== 3'd2 || irq_pending !== 8'h25) begin
      n_fail++;
      $display("FAIL prio_freeze: id=%0d pend=%h want 2/25",
               irq_id, irq_pending);
    end
    ExtIAck = 1'b1;
    tick(1);
    ExtIAck = 1'b0;
    n_run++;
    if (irq_pending !== 8'h21 || serviced_count !== 16'd2) begin
      n_fail++;
      $display("FAIL prio_ack: pend=%h cnt=%0d want 21/2",
               irq_pending, serviced_count);
    end
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    n_run++;
    if (ExtIRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_eret_lat: irq=%b want 0", ExtIRQ);
    end
    tick(1);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd0) begin
      n_fail++;
      $display("FAIL prio_next0: irq=%b id=%0d want 1/0", ExtIRQ, irq_id);
    end
    ExtIAck = 1'b1;
    tick(1);
    ExtIAck = 1'b0;
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    tick(1);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd5) begin
      n_fail++;
      $display("FAIL prio_next5: irq=%b id=%0d want 1/5", ExtIRQ, irq_id);
    end
    ExtIAck = 1'b1;
    tick(1);
    ExtIAck = 1'b0;
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    n_run++;
    if (serviced_count !== 16'd4 || irq_pending !== 8'h00) begin
      n_fail++;
      $display("FAIL prio_done: cnt=%0d pend=%h want 4/00",
               serviced_count, irq_pending);
    end
  endtask

  task automatic test_mask;
    mask_we = 1'b1; mask_wdata = 8'h10;
    tick(1);
    mask_we = 1'b0;
    n_run++;
    if (irq_mask !== 8'h10) begin
      n_fail++;
      $display("FAIL mask_wr: mask=%h want 10", irq_mask);
    end
    irq_in = 8'h10;
    tick(1);
    irq_in = 8'h00;
    tick(2);
    n_run++;
    if (irq_pending !== 8'h10 || ExtIRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_block: pend=%h irq=%b want 10/0",
               irq_pending, ExtIRQ);
    end
    mask_we = 1'b1; mask_wdata = 8'h00;
    tick(1);
    mask_we = 1'b0;
    n_run++;
    if (ExtIRQ !== 1'b0 || irq_mask !== 8'h00) begin
      n_fail++;
      $display("FAIL mask_clr_lat: irq=%b mask=%h want 0/00",
               ExtIRQ, irq_mask);
    end
    tick(1);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd4) begin
      n_fail++;
      $display("FAIL mask_unblock: irq=%b id=%0d want 1/4", ExtIRQ, irq_id);
    end
    mask_we = 1'b1; mask_wdata = 8'h10;
    tick(1);
    mask_we = 1'b0;
    tick(1);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd4) begin
      n_fail++;
      $display("FAIL mask_noretract: irq=%b id=%0d want 1/4",
               ExtIRQ, irq_id);
    end
    mask_we = 1'b1; mask_wdata = 8'h00;
    ExtIAck = 1'b1;
    tick(1);
    mask_we = 1'b0;
    ExtIAck = 1'b0;
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    n_run++;
    if (serviced_count !== 16'd5 || in_service !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_done: cnt=%0d svc=%b want 5/0",
               serviced_count, in_service);
    end
  endtask

  task automatic test_spurious;
    ExtIAck = 1'b1;
    tick(1);
    ExtIAck = 1'b0;
    n_run++;
    if (ExtIRQ !== 1'b0 || in_service !== 1'b0 ||
        serviced_count !== 16'd5) begin
      n_fail++;
      $display("FAIL spur_ack: irq=%b svc=%b cnt=%0d want 0/0/5",
               ExtIRQ, in_service, serviced_count);
    end
    irq_in = 8'h02;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    n_run++;
    if (ExtIRQ !== 1'b1 || in_service !== 1'b0 ||
        irq_id !== 3'd1 || serviced_count !== 16'd5) begin
      n_fail++;
      $display("FAIL spur_eret: irq=%b svc=%b id=%0d cnt=%0d want 1/0/1/5",
               ExtIRQ, in_service, irq_id, serviced_count);
    end
    ExtIAck = 1'b1;
    tick(1);
    ExtIAck = 1'b0;
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
  endtask

  task automatic test_collision;
    irq_in = 8'h40;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    ExtIAck = 1'b1;
    irq_in  = 8'h40;
    tick(1);
    ExtIAck = 1'b0;
    irq_in  = 8'h00;
    n_run++;
    if (irq_pending !== 8'h40 || in_service !== 1'b1 ||
        serviced_count !== 16'd7) begin
      n_fail++;
      $display("FAIL coll_ack: pend=%h svc=%b cnt=%0d want 40/1/7",
               irq_pending, in_service, serviced_count);
    end
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    tick(1);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd6) begin
      n_fail++;
      $display("FAIL coll_rereq: irq=%b id=%0d want 1/6", ExtIRQ, irq_id);
    end
    ExtIAck = 1'b1;
    tick(1);
    ExtIAck = 1'b0;
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    n_run++;
    if (serviced_count !== 16'd8 || irq_pending !== 8'h00) begin
      n_fail++;
      $display("FAIL coll_done: cnt=%0d pend=%h want 8/00",
               serviced_count, irq_pending);
    end
  endtask

  task automatic test_reset_mid;
    irq_in = 8'h80;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    ExtIAck = 1'b1;
    tick(1);
    ExtIAck = 1'b0;
    irq_in = 8'h81;
    tick(1);
    n_run++;
    if (irq_pending !== 8'h81 || in_service !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_setup: pend=%h svc=%b want 81/1",
               irq_pending, in_service);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_run++;
    if ({ExtIRQ, irq_id, irq_pending, irq_mask,
         in_service, serviced_count} !== '0) begin
      n_fail++;
      $display("FAIL rmid_reset: irq=%b id=%0d pend=%h svc=%b cnt=%0d want all 0",
               ExtIRQ, irq_id, irq_pending, in_service, serviced_count);
    end
    tick(1);
    n_run++;
    if (irq_pending !== 8'h81 || ExtIRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_edge: pend=%h irq=%b want 81/0",
               irq_pending, ExtIRQ);
    end
    tick(1);
    n_run++;
    if (ExtIRQ !== 1'b1 || irq_id !== 3'd0) begin
      n_fail++;
      $display("FAIL rmid_req: irq=%b id=%0d want 1/0", ExtIRQ, irq_id);
    end
    irq_in = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_spurious();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
